// File: rtl/if_id_reg_pkg.sv
// Shared MIPS pipeline definitions: exception codes, nop encoding, fetch window defaults
// and the ID-stage record carried by the IF/ID register.
package if_id_reg_pkg;

    localparam logic [4:0]  EXC_NONE      = 5'd0;
    localparam logic [4:0]  EXC_ADEL      = 5'd4;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_BASE = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_SIZE = 32'h0000_4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic        exc;
        logic [4:0]  exc_code;
    } id_stage_t;

    // jal/jalr link value; wraps modulo 2^32
    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

endpackage

// File: rtl/if_id_reg_addr_check.sv
// Combinational address-error check: misaligned word or outside [BASE, BASE+SIZE).
// Bounds are compared at 33 bits so BASE+SIZE cannot overflow.
module if_addr_check
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] BASE = DEF_IMEM_BASE,
    parameter logic [31:0] SIZE = DEF_IMEM_SIZE
) (
    input  logic [31:0] addr,
    output logic        fault
);

    logic [32:0] addr_ext_s;
    logic [32:0] lo_s;
    logic [32:0] hi_s;

    // Unsigned window and alignment test
    always_comb begin
        addr_ext_s = {1'b0, addr};
        lo_s       = {1'b0, BASE};
        hi_s       = {1'b0, BASE} + {1'b0, SIZE};
        fault      = (addr[1:0] != 2'b00) || (addr_ext_s < lo_s) || (addr_ext_s >= hi_s);
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: stall hold, flush-to-bubble, delay-slot tagging, fetch AdEL.
// Optional macro IF_ID_PERF_CNT_EN adds saturating stall/bubble performance counters.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
    parameter logic [31:0] IMEM_SIZE = DEF_IMEM_SIZE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_is_jump,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt,
`endif
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        id_bd,
    output logic        id_exc,
    output logic [4:0]  id_exc_code
);

    localparam id_stage_t RESET_STAGE = '{
        pc:       RESET_PC,
        pc8:      RESET_PC + 32'd8,
        instr:    NOP_INSTR,
        valid:    1'b0,
        bd:       1'b0,
        exc:      1'b0,
        exc_code: EXC_NONE
    };

    id_stage_t stage_q;
    id_stage_t stage_d;
    logic      fault_s;

    if_addr_check #(
        .BASE (IMEM_BASE),
        .SIZE (IMEM_SIZE)
    ) u_addr_check (
        .addr  (if_pc),
        .fault (fault_s)
    );

    // Next ID contents: flush beats stall beats load
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.pc       = if_pc;
            stage_d.pc8      = link_addr(if_pc);
            stage_d.instr    = NOP_INSTR;
            stage_d.valid    = 1'b0;
            stage_d.bd       = 1'b0;
            stage_d.exc      = 1'b0;
            stage_d.exc_code = EXC_NONE;
        end else if (stall) begin
            stage_d = stage_q;
        end else begin
            stage_d.pc    = if_pc;
            stage_d.pc8   = link_addr(if_pc);
            stage_d.valid = 1'b1;
            // a bubble in ID never marks its successor as a delay slot
            stage_d.bd    = id_is_jump & stage_q.valid;
            if (fault_s) begin
                stage_d.instr    = NOP_INSTR;
                stage_d.exc      = 1'b1;
                stage_d.exc_code = EXC_ADEL;
            end else begin
                stage_d.instr    = if_instr;
                stage_d.exc      = 1'b0;
                stage_d.exc_code = EXC_NONE;
            end
        end
    end

    // ID stage state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q <= RESET_STAGE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign id_pc       = stage_q.pc;
    assign id_pc8      = stage_q.pc8;
    assign id_instr    = stage_q.instr;
    assign id_valid    = stage_q.valid;
    assign id_bd       = stage_q.bd;
    assign id_exc      = stage_q.exc;
    assign id_exc_code = stage_q.exc_code;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: driver pushes hand-computed expectations, a negedge
// monitor pops and compares one entry per cycle.
module tb_if_id_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic        exc;
        logic [4:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        stall;
    logic        flush;
    logic        id_is_jump;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        id_bd;
    logic        id_exc;
    logic [4:0]  id_exc_code;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    if_id_reg dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .stall       (stall),
        .flush       (flush),
        .id_is_jump  (id_is_jump),
`ifdef IF_ID_PERF_CNT_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .id_pc       (id_pc),
        .id_pc8      (id_pc8),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .id_bd       (id_bd),
        .id_exc      (id_exc),
        .id_exc_code (id_exc_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per negedge, compared field by field
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_pc",       id_pc,              e.pc);
                chk("id_pc8",      id_pc8,             e.pc8);
                chk("id_instr",    id_instr,           e.instr);
                chk("id_valid",    {31'd0, id_valid},  {31'd0, e.valid});
                chk("id_bd",       {31'd0, id_bd},     {31'd0, e.bd});
                chk("id_exc",      {31'd0, id_exc},    {31'd0, e.exc});
                chk("id_exc_code", {27'd0, id_exc_code}, {27'd0, e.code});
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] pc8,
                                input logic [31:0] instr, input logic valid,
                                input logic bd, input logic exc);
        exp_t e;
        e.pc    = pc;
        e.pc8   = pc8;
        e.instr = instr;
        e.valid = valid;
        e.bd    = bd;
        e.exc   = exc;
        e.code  = exc ? 5'd4 : 5'd0;
        return e;
    endfunction

    // Drive one cycle's inputs just after the negedge and queue the post-edge expectation
    task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] instr,
                        input logic st, input logic fl, input logic jmp, input exp_t e);
        @(negedge clk);
        #1;
        rst        = r;
        if_pc      = pc;
        if_instr   = instr;
        stall      = st;
        flush      = fl;
        id_is_jump = jmp;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t rst_e;
        rst_e      = mk(32'h0000_3000, 32'h0000_3008, 32'h0, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        if_pc      = 32'h0000_3004;
        if_instr   = 32'h0;
        stall      = 1'b0;
        flush      = 1'b0;
        id_is_jump = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0000_3004, 32'h1234_5678, 1'b0, 1'b0, 1'b0, rst_e);
        end
        step(1'b1, 32'h0000_3000, 32'h3c01_0001, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_3000, 32'h0000_3008, 32'h3c01_0001, 1'b1, 1'b0, 1'b0));
        // two stall edges: everything holds
        step(1'b1, 32'h0000_3004, 32'h1111_1111, 1'b1, 1'b0, 1'b0,
             mk(32'h0000_3000, 32'h0000_3008, 32'h3c01_0001, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'h0000_3008, 32'h1111_1111, 1'b1, 1'b0, 1'b0,
             mk(32'h0000_3000, 32'h0000_3008, 32'h3c01_0001, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'h0000_3008, 32'h2222_2222, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_3008, 32'h0000_3010, 32'h2222_2222, 1'b1, 1'b0, 1'b0));
        // stall and flush together: flush wins
        step(1'b1, 32'h0000_300c, 32'h3333_3333, 1'b1, 1'b1, 1'b1,
             mk(32'h0000_300c, 32'h0000_3014, 32'h0, 1'b0, 1'b0, 1'b0));
        // bubble in ID: jump flag ignored
        step(1'b1, 32'h0000_3010, 32'h1000_0005, 1'b0, 1'b0, 1'b1,
             mk(32'h0000_3010, 32'h0000_3018, 32'h1000_0005, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'h0000_3014, 32'h4444_4444, 1'b0, 1'b0, 1'b1,
             mk(32'h0000_3014, 32'h0000_301c, 32'h4444_4444, 1'b1, 1'b1, 1'b0));
        step(1'b1, 32'h0000_3018, 32'h5555_5555, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_3018, 32'h0000_3020, 32'h5555_5555, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'h0000_301c, 32'h5555_0000, 1'b0, 1'b1, 1'b0,
             mk(32'h0000_301c, 32'h0000_3024, 32'h0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 32'h0000_3020, 32'h6666_6666, 1'b0, 1'b0, 1'b1,
             mk(32'h0000_3020, 32'h0000_3028, 32'h6666_6666, 1'b1, 1'b0, 1'b0));
        // address errors and window boundaries
        step(1'b1, 32'h0000_3002, 32'h7777_7777, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_3002, 32'h0000_300a, 32'h0, 1'b1, 1'b0, 1'b1));
        step(1'b1, 32'h0000_7000, 32'h7777_7777, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_7000, 32'h0000_7008, 32'h0, 1'b1, 1'b0, 1'b1));
        step(1'b1, 32'h0000_6ffc, 32'h8888_8888, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_6ffc, 32'h0000_7004, 32'h8888_8888, 1'b1, 1'b0, 1'b0));
        step(1'b1, 32'h0000_2ffc, 32'h8888_8888, 1'b0, 1'b0, 1'b0,
             mk(32'h0000_2ffc, 32'h0000_3004, 32'h0, 1'b1, 1'b0, 1'b1));
        step(1'b1, 32'hffff_fffc, 32'h9999_9999, 1'b0, 1'b0, 1'b0,
             mk(32'hffff_fffc, 32'h0000_0004, 32'h0, 1'b1, 1'b0, 1'b1));

        // hold the faulting instruction, then pull reset low between edges
        @(negedge clk);
        #1;
        stall = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.push_back(rst_e);
        step(1'b0, 32'h0000_3004, 32'h0, 1'b1, 1'b1, 1'b1, rst_e);
        step(1'b1, 32'h0000_3040, 32'habcd_ef01, 1'b0, 1'b0, 1'b1,
             mk(32'h0000_3040, 32'h0000_3048, 32'habcd_ef01, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register of the 5-stage MIPS core.
- Sits directly downstream of the PC register and instruction memory. Captures the fetched PC and instruction each cycle and presents them to the decode stage.
- Adds stall hold, flush-to-bubble, branch-delay-slot tagging and fetch address-error (AdEL) detection, for use by hazard control and the later CP0 stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value presented while in reset / before the first fetch.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_4000, legal fetch window size in bytes; legal range is [IMEM_BASE, IMEM_BASE+IMEM_SIZE).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- if_pc  in  32  PC of the instruction fetched this cycle (PC register output).
- if_instr  in  32  instruction memory read data for if_pc.
- stall  in  1  hazard unit: hold ID contents.
- flush  in  1  exception/eret: replace ID contents with a bubble.
- id_is_jump  in  1  decoder: the instruction currently in ID is a branch or jump.
- id_pc  out  32  PC of the ID-stage instruction.
- id_pc8  out  32  id_pc + 8, the jal/jalr link value.
- id_instr  out  32  ID-stage instruction; 0 (nop) for bubbles and faulting fetches.
- id_valid  out  1  ID holds a real instruction.
- id_bd  out  1  ID instruction sits in a branch delay slot.
- id_exc  out  1  fetch exception pending for the ID instruction.
- id_exc_code  out  5  ExcCode: 5'd4 (AdEL) when id_exc=1, else 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - id_pc=RESET_PC, id_pc8=RESET_PC+8, id_instr=0.
  - id_valid=0, id_bd=0, id_exc=0, id_exc_code=0.
- Deassertion of rst takes effect at the next clk edge; the first load happens on the first rising edge with rst=1.
- Per-edge priority is flush > stall > load.
- Flush:
  - id_instr=0, id_valid=0, id_bd=0, id_exc=0, id_exc_code=0.
  - id_pc<=if_pc and id_pc8<=if_pc+8, so downstream bubbles carry a sane PC.
- Stall (flush=0): every output holds its value. A stall lasting N cycles holds for exactly N edges.
- Load (flush=0, stall=0):
  - id_pc<=if_pc, id_pc8<=if_pc+8 (modulo 2^32, wraps silently), id_valid<=1.
  - id_bd<=id_is_jump & id_valid, sampled from the current ID contents before the update.
  - Fault test: if_pc[1:0]!=0, or if_pc<IMEM_BASE, or if_pc>=IMEM_BASE+IMEM_SIZE. The comparison is unsigned and 33-bit, so IMEM_BASE+IMEM_SIZE does not overflow.
  - On fault: id_instr<=0, id_exc<=1, id_exc_code<=4.
  - Otherwise: id_instr<=if_instr, id_exc<=0, id_exc_code<=0.
- Latency: 1 cycle from IF to ID. There is no combinational path from any input to any output.
- Stall and flush in the same cycle: the flush wins and the bubble is loaded.
- id_is_jump is ignored while id_valid=0, so a bubble never tags its successor as a delay slot.
- Reset asserted mid-stall or mid-flush clears all state immediately.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0 by rst.
  - perf_stall_cnt increments on each edge with stall=1 and flush=0.
  - perf_bubble_cnt increments on each edge with flush=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- When not defined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package/header: EXC_ADEL=5'd4, EXC_NONE=5'd0, NOP_INSTR=32'h0, default RESET_PC/IMEM_BASE/IMEM_SIZE. The mips_defs header also serves the PC, CP0 and later pipeline registers.
- One sub-module: if_addr_check, combinational. Takes if_pc plus window parameters and returns fault. It is reused later by the MEM-stage AdEL/AdES check.
- Counters stay inline under the macro.

Test Plan:
- Reset: hold rst=0 for 3 cycles with if_pc=0x3004 → id_pc=0x3000, id_pc8=0x3008, id_valid=0, id_instr=0. Release rst with if_pc=0x3000, if_instr=0x3c010001 → after 1 edge, id_pc=0x3000, id_instr=0x3c010001, id_valid=1.
- Stall: hold stall=1 for 2 edges while if_pc advances 0x3004→0x3008 → id_pc stays 0x3000 and id_instr unchanged. Release stall → id_pc=0x3008 on the next edge.
- Flush vs stall: assert stall=1 and flush=1 together with if_pc=0x300c → id_instr=0, id_valid=0, id_pc=0x300c, id_bd=0. With the optional macro, perf_bubble_cnt=1 and perf_stall_cnt is unchanged.
- Delay slot: load beq at 0x3010, drive id_is_jump=1, load 0x3014 → id_bd=1. Next load at 0x3018 with id_is_jump=0 → id_bd=0. Repeat with a bubble in ID → id_bd=0.
- AdEL: if_pc=0x3002 → id_exc=1, id_exc_code=4, id_instr=0, id_valid=1. Also if_pc=0x7000 → AdEL. if_pc=0x6ffc → no exception.
- Async reset mid-operation: pull rst low between clock edges while id_valid=1 and id_exc=1 → all outputs return to reset values before the next edge.
